avalon_arbiter: RTL and testbench
=================================

// Module: avalon_arbiter
// PURPOSE
//  Shares one Avalon-MM master port between the CPU instruction-fetch requester (I) and the
//  load/store requester (D). Round-robin arbitration, one transfer per grant, plus a
//  waitrequest timeout that completes a hung transfer with an error.
//  Sits between the CPU memory ports and the Avalon memory/peripheral fabric.
// PARAMETERS
//  ADDR_W   32   address width, both requesters and master
//  DATA_W   32   data width; byteenable width is DATA_W/8
//  TIMEOUT  255  max consecutive av_waitrequest=1 cycles while granted before abort (>=1)
// PORTS
//  clk            in   1        clock, all state on rising edge
//  reset          in   1        asynchronous, active-high reset
//  i_address      in   ADDR_W   I requester address
//  i_read         in   1        I read request
//  i_readdata     out  DATA_W   I read data, valid in the I completion cycle
//  i_waitrequest  out  1        0 only in the I completion cycle
//  d_address      in   ADDR_W   D requester address, already word aligned
//  d_read         in   1        D read request
//  d_write        in   1        D write request
//  d_writedata    in   DATA_W   D write data, already lane aligned
//  d_byteenable   in   DATA_W/8 D byte lanes
//  d_readdata     out  DATA_W   D read data, valid in the D completion cycle
//  d_waitrequest  out  1        0 only in the D completion cycle
//  av_address     out  ADDR_W   master address
//  av_read        out  1        master read
//  av_write       out  1        master write
//  av_writedata   out  DATA_W   master write data
//  av_byteenable  out  DATA_W/8 master byte lanes
//  av_readdata    in   DATA_W   fabric read data
//  av_waitrequest in   1        fabric stall
//  grant          out  2        one-hot current owner: [0]=I, [1]=D
//  bus_error      out  1        sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, last=I so D wins the first tie. av_read/av_write/av_address/
//   av_writedata/av_byteenable=0, grant=0, i_/d_waitrequest=1, bus_error=0, timer=0.
//   Reset takes effect asynchronously, including mid-transfer; the aborted transfer is not completed.
//  Request qualification: I requests when i_read=1. D requests when d_read XOR d_write.
//   d_read=d_write=1 is illegal and is ignored (D treated as idle).
//  FSM (registered state; outputs decoded from state and the granted requester):
//   IDLE    : av_read/av_write=0. Samples requests.
//             Only I -> GRANT_I. Only D -> GRANT_D. Both -> owner != last. None -> IDLE.
//   GRANT_I : av_* = {i_address, i_read, write=0, wdata=0, be=all 1s}; grant=01.
//   GRANT_D : av_* = D signals passed through; grant=10.
//             In GRANT_x: if av_waitrequest=0, this is the completion cycle: x_waitrequest=0,
//             x_readdata=av_readdata, last<=x, next state IDLE.
//             If av_waitrequest=1: timer++. When timer reaches TIMEOUT -> ERROR.
//             If the owner drops its request while granted (protocol violation):
//             av_read/av_write are forced to 0 that cycle, the transfer is not completed, next state IDLE.
//   ERROR   : av_read/av_write=0; owner x_waitrequest=0 with x_readdata={DATA_W/16{16'hDEAD}};
//             bus_error<=1; last<=x; next state IDLE.
//  Timer: cleared on entry to every GRANT state; saturating; width clog2(TIMEOUT+1).
//  Latency: request visible in IDLE -> earliest completion 1 cycle later (2 cycles total).
//   One IDLE cycle between consecutive transfers. With both requesting continuously,
//   grants alternate D,I,D,I...
//  Non-owner: x_waitrequest=1 throughout; x_readdata=0.
//  Requester signals must be held stable while their waitrequest=1 (Avalon rule).
//   The arbiter does not register them.
// TESTING
//  1 Reset mid-GRANT_D write (av_waitrequest=1): reset=1 -> av_write=0, d_waitrequest=1, grant=0
//    in the same cycle; bus_error=0.
//  2 Lone I read, addr 0x0000_0040, av_waitrequest 0 in the first grant cycle, av_readdata 0x2402_0005
//    -> grant=01 one cycle after request; i_readdata=0x2402_0005 and i_waitrequest=0 for exactly 1 cycle.
//  3 I and D (write 0x1234_5678, be 4'b0011, addr 0x100) both asserted from reset:
//    -> D completes first, then I, then D; one IDLE cycle between grants.
//  4 D read with av_waitrequest held 1, TIMEOUT=4 -> ERROR after 4 stalled cycles;
//    d_readdata=0xDEADDEAD; bus_error=1 and stays 1; the next I read completes normally.
//  5 d_read=d_write=1 while I idle -> no grant, av_read=av_write=0; then I request -> granted normally.
//  6 Owner drops i_read during a stall -> av_read=0 that cycle, no completion; back to IDLE next cycle.

Source files
------------

// File: rtl/avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the instruction-fetch
// requester (I, read only) and the load/store requester (D). One transfer per
// grant, an IDLE cycle between grants, and a waitrequest timeout that ends a
// hung transfer with an error response and a sticky bus_error flag.
module avalon_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction-fetch requester
  input  logic [ADDR_W-1:0]     i_address,
  input  logic                  i_read,
  output logic [DATA_W-1:0]     i_readdata,
  output logic                  i_waitrequest,
  // load/store requester
  input  logic [ADDR_W-1:0]     d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_W-1:0]     d_writedata,
  input  logic [DATA_W/8-1:0]   d_byteenable,
  output logic [DATA_W-1:0]     d_readdata,
  output logic                  d_waitrequest,
  // shared master
  output logic [ADDR_W-1:0]     av_address,
  output logic                  av_read,
  output logic                  av_write,
  output logic [DATA_W-1:0]     av_writedata,
  output logic [DATA_W/8-1:0]   av_byteenable,
  input  logic [DATA_W-1:0]     av_readdata,
  input  logic                  av_waitrequest,
  // status
  output logic [1:0]            grant,
  output logic                  bus_error
);

  localparam int                TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = {(DATA_W/16){16'hDEAD}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t           state;
  logic             last_d;   // 1: D owned the most recent completed/aborted transfer
  logic             err_d;    // 1: the transfer that timed out belonged to D
  logic [TMR_W-1:0] timer;

  logic i_req;
  logic d_req;
  logic own_req;

  // D asserting read and write together is illegal and counts as no request.
  assign i_req   = i_read;
  assign d_req   = d_read ^ d_write;
  assign own_req = (state == S_GRANT_I) ? i_req : d_req;

  // Arbitration FSM, round-robin pointer, stall timer and sticky error flag.
  // NOTE: async reset puts the FSM in IDLE immediately, so the decoded bus
  // outputs drop in the same cycle and an in-flight transfer is abandoned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      last_d    <= 1'b0;
      err_d     <= 1'b0;
      timer     <= '0;
      bus_error <= 1'b0;
    end else begin
      // NOTE: all state here uses <= so every register samples pre-edge values.
      unique case (state)
        S_IDLE: begin
          // Clearing in IDLE clears on entry to every grant, the only path in.
          timer <= '0;
          if (i_req && d_req) state <= last_d ? S_GRANT_I : S_GRANT_D;
          else if (d_req)     state <= S_GRANT_D;
          else if (i_req)     state <= S_GRANT_I;
        end
        S_GRANT_I, S_GRANT_D: begin
          if (!own_req) begin
            // Owner withdrew mid-transfer: abandon without completing.
            state <= S_IDLE;
          end else if (!av_waitrequest) begin
            state  <= S_IDLE;
            last_d <= (state == S_GRANT_D);
          end else if (timer >= TMR_LAST) begin
            // This stall is the TIMEOUT-th consecutive one.
            state <= S_ERROR;
            err_d <= (state == S_GRANT_D);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_ERROR: begin
          bus_error <= 1'b1;
          last_d    <= err_d;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Master and requester-side outputs decoded from state and the owner.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    av_address    = '0;
    av_read       = 1'b0;
    av_write      = 1'b0;
    av_writedata  = '0;
    av_byteenable = '0;
    grant         = 2'b00;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    unique case (state)
      S_GRANT_I: begin
        grant         = 2'b01;
        av_address    = i_address;
        av_read       = i_read;
        av_byteenable = '1;
        if (i_req && !av_waitrequest) begin
          i_waitrequest = 1'b0;
          i_readdata    = av_readdata;
        end
      end
      S_GRANT_D: begin
        grant         = 2'b10;
        av_address    = d_address;
        av_writedata  = d_writedata;
        av_byteenable = d_byteenable;
        // A dropped or illegal D request forces the strobes low.
        av_read       = d_read  & d_req;
        av_write      = d_write & d_req;
        if (d_req && !av_waitrequest) begin
          d_waitrequest = 1'b0;
          d_readdata    = av_readdata;
        end
      end
      S_ERROR: begin
        if (err_d) begin
          d_waitrequest = 1'b0;
          d_readdata    = ERR_DATA;
        end else begin
          i_waitrequest = 1'b0;
          i_readdata    = ERR_DATA;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed bench for avalon_arbiter. Stimulus pushes each expected completion
// (port and read data) into a scoreboard queue; a monitor pops and compares
// whenever either requester sees waitrequest low.
module tb_avalon_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [DATA_W-1:0] i_readdata;
  logic              i_waitrequest;
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [DATA_W-1:0] d_writedata;
  logic [3:0]        d_byteenable;
  logic [DATA_W-1:0] d_readdata;
  logic              d_waitrequest;
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [DATA_W-1:0] av_writedata;
  logic [3:0]        av_byteenable;
  logic [DATA_W-1:0] av_readdata;
  logic              av_waitrequest;
  logic [1:0]        grant;
  logic              bus_error;

  avalon_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_address      (i_address),
    .i_read         (i_read),
    .i_readdata     (i_readdata),
    .i_waitrequest  (i_waitrequest),
    .d_address      (d_address),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_writedata    (d_writedata),
    .d_byteenable   (d_byteenable),
    .d_readdata     (d_readdata),
    .d_waitrequest  (d_waitrequest),
    .av_address     (av_address),
    .av_read        (av_read),
    .av_write       (av_write),
    .av_writedata   (av_writedata),
    .av_byteenable  (av_byteenable),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest),
    .grant          (grant),
    .bus_error      (bus_error)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every completion must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && (!i_waitrequest || !d_waitrequest)) begin
        check("single_completion", 32'(i_waitrequest ^ d_waitrequest), 32'd1);
        if (sb.size() == 0) begin
          check("sb_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_port", 32'(!d_waitrequest), 32'(e.is_d));
          check("sb_data", !d_waitrequest ? d_readdata : i_readdata, e.data);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] both_seq [6];

  initial begin
    reset          = 1'b1;
    i_address      = '0;
    i_read         = 1'b0;
    d_address      = '0;
    d_read         = 1'b0;
    d_write        = 1'b0;
    d_writedata    = '0;
    d_byteenable   = '0;
    av_readdata    = '0;
    av_waitrequest = 1'b1;
    #1;

    // Reset state
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_av_rw", 32'({av_read, av_write}), 32'd0);
    check("rst_av_addr", av_address, 32'd0);
    check("rst_wait", 32'({i_waitrequest, d_waitrequest}), 32'd3);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    step();

    // Lone I read completing in its first grant cycle
    reset          = 1'b0;
    i_address      = 32'h0000_0040;
    i_read         = 1'b1;
    av_waitrequest = 1'b0;
    av_readdata    = 32'h2402_0005;
    expect_done(1'b0, 32'h2402_0005);
    check("i_idle_wait", 32'(i_waitrequest), 32'd1);
    step();
    check("i_grant", 32'(grant), 32'b01);
    check("i_av_addr", av_address, 32'h0000_0040);
    check("i_av_read", 32'({av_read, av_write}), 32'b10);
    check("i_av_be", 32'(av_byteenable), 32'hF);
    check("i_done_wait", 32'(i_waitrequest), 32'd0);
    step();
    i_read = 1'b0;
    check("i_one_cycle", 32'(i_waitrequest), 32'd1);
    check("i_post_grant", 32'(grant), 32'd0);

    // Both requesting from reset: D, I, D with an IDLE between grants
    reset = 1'b1;
    step();
    i_address      = 32'h0000_0080;
    i_read         = 1'b1;
    d_address      = 32'h0000_0100;
    d_write        = 1'b1;
    d_writedata    = 32'h1234_5678;
    d_byteenable   = 4'b0011;
    av_readdata    = 32'h1111_2222;
    av_waitrequest = 1'b0;
    expect_done(1'b1, 32'h1111_2222);
    expect_done(1'b0, 32'h1111_2222);
    expect_done(1'b1, 32'h1111_2222);
    reset = 1'b0;
    both_seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(both_seq[k]));
      if (k == 0) begin
        check("rr_d_addr", av_address, 32'h0000_0100);
        check("rr_d_wdata", av_writedata, 32'h1234_5678);
        check("rr_d_be", 32'(av_byteenable), 32'b0011);
        check("rr_d_rw", 32'({av_read, av_write}), 32'b01);
      end
    end
    i_read  = 1'b0;
    d_write = 1'b0;

    // Illegal D (read and write together) is ignored; I then wins normally
    d_read  = 1'b1;
    d_write = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ill_grant_%0d", k), 32'(grant), 32'd0);
      check($sformatf("ill_av_rw_%0d", k), 32'({av_read, av_write}), 32'd0);
      check($sformatf("ill_d_wait_%0d", k), 32'(d_waitrequest), 32'd1);
    end
    i_address   = 32'h0000_0044;
    i_read      = 1'b1;
    av_readdata = 32'hCAFE_0001;
    expect_done(1'b0, 32'hCAFE_0001);
    step();
    check("ill_i_grant", 32'(grant), 32'b01);
    step();
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;

    // Owner drops i_read during a stall
    av_waitrequest = 1'b1;
    i_address      = 32'h0000_0048;
    i_read         = 1'b1;
    step();
    check("drop_grant", 32'(grant), 32'b01);
    check("drop_av_read_before", 32'(av_read), 32'd1);
    step();
    i_read = 1'b0;
    #1;
    check("drop_av_read", 32'(av_read), 32'd0);
    check("drop_no_done", 32'(i_waitrequest), 32'd1);
    step();
    check("drop_idle", 32'(grant), 32'd0);

    // D read timeout after TIMEOUT stalled cycles
    d_address = 32'h0000_0200;
    d_read    = 1'b1;
    expect_done(1'b1, 32'hDEAD_DEAD);
    for (int k = 0; k < TIMEOUT; k++) begin
      step();
      check($sformatf("to_grant_%0d", k), 32'(grant), 32'b10);
      check($sformatf("to_stall_%0d", k), 32'({av_read, d_waitrequest}), 32'b11);
    end
    step();
    check("to_err_av_rw", 32'({av_read, av_write}), 32'd0);
    check("to_err_wait", 32'(d_waitrequest), 32'd0);
    check("to_err_data", d_readdata, 32'hDEAD_DEAD);
    d_read = 1'b0;
    step();
    check("to_bus_error", 32'(bus_error), 32'd1);
    av_waitrequest = 1'b0;
    av_readdata    = 32'h0BAD_F00D;
    i_address      = 32'h0000_004C;
    i_read         = 1'b1;
    expect_done(1'b0, 32'h0BAD_F00D);
    step();
    check("to_i_grant", 32'(grant), 32'b01);
    check("to_i_done", 32'(i_waitrequest), 32'd0);
    step();
    i_read = 1'b0;
    check("to_bus_error_sticky", 32'(bus_error), 32'd1);

    // Reset asserted mid-GRANT_D write while stalled
    av_waitrequest = 1'b1;
    d_address      = 32'h0000_0100;
    d_write        = 1'b1;
    d_writedata    = 32'h1234_5678;
    d_byteenable   = 4'b0011;
    step();
    check("mid_av_write", 32'(av_write), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_av_write", 32'(av_write), 32'd0);
    check("mid_rst_d_wait", 32'(d_waitrequest), 32'd1);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_bus_error", 32'(bus_error), 32'd0);
    step();
    d_write = 1'b0;
    reset   = 1'b0;
    step();
    step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
